led_display_row_driver: RTL and testbench

- Downstream stage of the pattern generator. Accepts one rgb_row_t per handshake, shifts it serially into a HUB75-style dual-scan panel, then latches it and drives the row address and output enable.
- Display time per row is fixed, with blanking around address changes.
- Owns all panel-facing pins; the pattern generator never touches the panel.

---
 rtl/led_display_row_driver_pkg.sv | 45 ++++
 rtl/led_display_row_driver_if.sv | 14 +
 rtl/led_display_shift_clk_gen.sv | 45 ++++
 rtl/led_display_row_driver.sv | 189 ++++++++++++++++++
 tb/tb_led_display_row_driver.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_display_row_driver_pkg.sv
// Shared types for the LED panel datapath: row payload, HUB75 pin group and row-driver FSM states.
package led_display_row_driver_pkg;

  localparam int unsigned GL_NUM_COL_PIXELS = 32;
  localparam int unsigned GL_PIX_IDX_W      = $clog2(GL_NUM_COL_PIXELS);
  localparam int unsigned GL_ROW_ADDR_W     = 4;

  typedef struct packed {
    logic [GL_NUM_COL_PIXELS-1:0] red;
    logic [GL_NUM_COL_PIXELS-1:0] green;
    logic [GL_NUM_COL_PIXELS-1:0] blue;
  } rgb_plane_t;

  typedef struct packed {
    rgb_plane_t top;
    rgb_plane_t bot;
  } rgb_row_t;

  localparam int unsigned GL_RGB_ROW_W = $bits(rgb_row_t);

  // One HUB75 colour pin group, packed as {B,G,R}
  typedef struct packed {
    logic b;
    logic g;
    logic r;
  } hub75_rgb_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } row_drv_state_t;

  function automatic hub75_rgb_t pixel_pins(input rgb_plane_t p,
                                            input logic [GL_PIX_IDX_W-1:0] col);
    hub75_rgb_t pins;
    pins.b = p.blue[col];
    pins.g = p.green[col];
    pins.r = p.red[col];
    return pins;
  endfunction

endpackage

// File: rtl/led_display_row_driver_if.sv
// Row handshake between the pattern generator (master) and the panel row driver (slave).
interface led_display_row_driver_if;
  import led_display_row_driver_pkg::*;

  rgb_row_t                 row_in;
  logic                     row_valid_in;
  logic                     row_ready_out;
  logic [GL_ROW_ADDR_W-1:0] row_address_in;

  modport master (output row_in, output row_valid_in, output row_address_in,
                  input  row_ready_out);
  modport slave  (input  row_in, input  row_valid_in, input  row_address_in,
                  output row_ready_out);
endinterface

// File: rtl/led_display_shift_clk_gen.sv
// Panel shift-clock divider and pixel counter; both counters hold at zero unless run is high.
module led_display_shift_clk_gen
  import led_display_row_driver_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic                    clk_in,
  input  logic                    n_reset_in,
  input  logic                    run,
  output logic [GL_PIX_IDX_W-1:0] pix_idx,
  output logic                    panel_clk_c,
  output logic                    shift_done_c
);

  localparam int unsigned DIV_W = $clog2(DIV);

  logic [DIV_W-1:0]        div_q;
  logic [GL_PIX_IDX_W-1:0] pix_q;
  logic                    div_last_c;
  logic                    pix_last_c;

  assign div_last_c = (div_q == DIV_W'(DIV - 1));
  assign pix_last_c = (pix_q == GL_PIX_IDX_W'(GL_NUM_COL_PIXELS - 1));

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      div_q <= '0;
      pix_q <= '0;
    end else if (!run) begin
      div_q <= '0;
      pix_q <= '0;
    end else if (div_last_c) begin
      div_q <= '0;
      pix_q <= pix_last_c ? '0 : pix_q + GL_PIX_IDX_W'(1);
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Low half of each pixel period presents data, high half clocks it in
  assign panel_clk_c  = run && (div_q >= DIV_W'(DIV / 2));
  assign shift_done_c = run && div_last_c && pix_last_c;
  assign pix_idx      = pix_q;

endmodule

// File: rtl/led_display_row_driver.sv
// HUB75 dual-scan row driver: accepts one row, shifts it out, blanks, latches, then displays.
// Optional LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN adds brightness_in to scale OE on-time.
module led_display_row_driver
  import led_display_row_driver_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ   = 100_000_000,
  parameter int unsigned SHIFT_CLK_DIV  = 4,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned LATCH_CYCLES   = 2,
  parameter int unsigned DISPLAY_CYCLES = 1000
) (
  input  logic                     clk_in,
  input  logic                     n_reset_in,
  led_display_row_driver_if.slave  row_if,
`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
  input  logic [7:0]               brightness_in,
`endif
  output hub75_rgb_t               panel_top_rgb_out,
  output hub75_rgb_t               panel_bot_rgb_out,
  output logic                     panel_clk_out,
  output logic                     panel_lat_out,
  output logic                     panel_oe_n_out,
  output logic [GL_ROW_ADDR_W-1:0] panel_addr_out
);

  localparam int unsigned MAX_BL    = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
  localparam int unsigned PHASE_MAX = (DISPLAY_CYCLES > MAX_BL) ? DISPLAY_CYCLES : MAX_BL;
  localparam int unsigned CNT_W     = $clog2(PHASE_MAX + 1);

  if (SHIFT_CLK_DIV < 2 || (SHIFT_CLK_DIV % 2) != 0) begin : g_bad_div
    $error("SHIFT_CLK_DIV must be even and >= 2");
  end
  if (BLANK_CYCLES < 1 || LATCH_CYCLES < 1 || DISPLAY_CYCLES < 1) begin : g_bad_phase
    $error("BLANK_CYCLES, LATCH_CYCLES and DISPLAY_CYCLES must be >= 1");
  end
  if (SYS_CLK_FREQ < SHIFT_CLK_DIV) begin : g_bad_freq
    $error("SYS_CLK_FREQ too low for SHIFT_CLK_DIV");
  end

  row_drv_state_t           state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  rgb_row_t                 row_hold_q, row_hold_d;
  logic [GL_ROW_ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic                     ready_q, ready_d;
  hub75_rgb_t               top_q, top_d, bot_q, bot_d;
  logic                     clk_q, clk_d, lat_q, lat_d, oe_n_q, oe_n_d;
  logic [GL_ROW_ADDR_W-1:0] addr_q, addr_d;
  logic                     display_on_c;

  logic [GL_PIX_IDX_W-1:0]  pix_idx;
  logic [GL_PIX_IDX_W-1:0]  col_c;
  logic                     shift_clk_c;
  logic                     shift_done_c;

  led_display_shift_clk_gen #(.DIV(SHIFT_CLK_DIV)) u_shift_clk_gen (
    .clk_in       (clk_in),
    .n_reset_in   (n_reset_in),
    .run          (state_q == ST_SHIFT),
    .pix_idx      (pix_idx),
    .panel_clk_c  (shift_clk_c),
    .shift_done_c (shift_done_c)
  );

  // Highest column leaves first
  assign col_c = GL_PIX_IDX_W'(GL_NUM_COL_PIXELS - 1) - pix_idx;

`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
  localparam int unsigned PROD_W = CNT_W + 8;
  logic [CNT_W-1:0] bright_lim_q, bright_lim_d;
  assign display_on_c = (cnt_q < bright_lim_q);
`else
  assign display_on_c = 1'b1;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_hold_d  = row_hold_q;
    addr_hold_d = addr_hold_q;
    ready_d     = 1'b0;
    top_d       = '0;
    bot_d       = '0;
    clk_d       = 1'b0;
    lat_d       = 1'b0;
    oe_n_d      = 1'b1;
    addr_d      = addr_q;
`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
    bright_lim_d = bright_lim_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (row_if.row_valid_in && ready_q) begin
          row_hold_d  = row_if.row_in;
          addr_hold_d = row_if.row_address_in;
          ready_d     = 1'b0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        clk_d = shift_clk_c;
        top_d = pixel_pins(row_hold_q.top, col_c);
        bot_d = pixel_pins(row_hold_q.bot, col_c);
        if (shift_done_c) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LATCH: begin
        lat_d = 1'b1;
        if (cnt_q == '0) addr_d = addr_hold_q;
        if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
          state_d = ST_DISPLAY;
          cnt_d   = '0;
`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
          bright_lim_d = CNT_W'((PROD_W'(DISPLAY_CYCLES) * PROD_W'(brightness_in)) >> 8);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DISPLAY: begin
        oe_n_d = !display_on_c;
        if (cnt_q == CNT_W'(DISPLAY_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      row_hold_q  <= '0;
      addr_hold_q <= '0;
      ready_q     <= 1'b0;
      top_q       <= '0;
      bot_q       <= '0;
      clk_q       <= 1'b0;
      lat_q       <= 1'b0;
      oe_n_q      <= 1'b1;
      addr_q      <= '0;
`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
      bright_lim_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_hold_q  <= row_hold_d;
      addr_hold_q <= addr_hold_d;
      ready_q     <= ready_d;
      top_q       <= top_d;
      bot_q       <= bot_d;
      clk_q       <= clk_d;
      lat_q       <= lat_d;
      oe_n_q      <= oe_n_d;
      addr_q      <= addr_d;
`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
      bright_lim_q <= bright_lim_d;
`endif
    end
  end

  assign row_if.row_ready_out = ready_q;
  assign panel_top_rgb_out    = top_q;
  assign panel_bot_rgb_out    = bot_q;
  assign panel_clk_out        = clk_q;
  assign panel_lat_out        = lat_q;
  assign panel_oe_n_out       = oe_n_q;
  assign panel_addr_out       = addr_q;

endmodule

// File: tb/tb_led_display_row_driver.sv
// Self-checking bench for led_display_row_driver: table vectors, random back-to-back rows, async reset.
module tb_led_display_row_driver;
  import led_display_row_driver_pkg::*;

  localparam int N   = GL_NUM_COL_PIXELS;
  localparam int DIV = 4;
  localparam int B   = 2;
  localparam int L   = 2;
  localparam int D   = 1000;
  localparam int FIRST_RISE_K = 1 + DIV / 2;
  localparam int LAT_K        = 1 + N * DIV + B;
  localparam int OE_K         = LAT_K + L;
  localparam int READY_K      = OE_K + D;
`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  typedef struct {
    rgb_row_t   row;
    logic [3:0] addr;
    logic [7:0] bright;
    bit         churn;
    int         exp_oe_low;
  } vec_t;

  typedef struct {
    int         first_rise;
    int         rises;
    rgb_row_t   seen;
    int         lat_start;
    int         lat_len;
    logic [3:0] lat_addr;
    int         oe_start;
    int         oe_low;
    int         ready_at;
  } res_t;

  logic       clk_in = 1'b0;
  logic       n_reset_in;
  hub75_rgb_t panel_top_rgb_out, panel_bot_rgb_out;
  logic       panel_clk_out, panel_lat_out, panel_oe_n_out;
  logic [3:0] panel_addr_out;
`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
  logic [7:0] brightness_in;
`endif

  led_display_row_driver_if row_if();

  led_display_row_driver #(
    .SYS_CLK_FREQ(100_000_000), .SHIFT_CLK_DIV(DIV), .BLANK_CYCLES(B),
    .LATCH_CYCLES(L), .DISPLAY_CYCLES(D)
  ) dut (
    .clk_in            (clk_in),
    .n_reset_in        (n_reset_in),
    .row_if            (row_if),
`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
    .brightness_in     (brightness_in),
`endif
    .panel_top_rgb_out (panel_top_rgb_out),
    .panel_bot_rgb_out (panel_bot_rgb_out),
    .panel_clk_out     (panel_clk_out),
    .panel_lat_out     (panel_lat_out),
    .panel_oe_n_out    (panel_oe_n_out),
    .panel_addr_out    (panel_addr_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int inv_fail = 0;
  logic [3:0] prev_addr = '0;

  // Panel safety invariants, checked every cycle outside reset
  always @(negedge clk_in) begin
    if (n_reset_in) begin
      assert (!(panel_lat_out && !panel_oe_n_out))
        else begin inv_fail++; $display("FAIL oe_during_lat at %0t: lat=1 oe_n=0", $time); end
      assert (!((panel_addr_out != prev_addr) && !panel_oe_n_out))
        else begin inv_fail++; $display("FAIL oe_during_addr_change at %0t: addr %0d->%0d oe_n=0",
                                        $time, prev_addr, panel_addr_out); end
    end
    prev_addr = panel_addr_out;
  end

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_row(input string name, input rgb_row_t act, input rgb_row_t exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic rgb_row_t rand_row();
    rgb_row_t r;
    r.top.red   = $urandom;
    r.top.green = $urandom;
    r.top.blue  = $urandom;
    r.bot.red   = $urandom;
    r.bot.green = $urandom;
    r.bot.blue  = $urandom;
    return r;
  endfunction

  // OE-low cycles per row derived from the brightness rule
  function automatic int oe_model(input int b);
    return BR ? ((D * b) >> 8) : D;
  endfunction

  // Drives one handshake and records what the panel pins do until ready returns
  task automatic run_row(input vec_t v, output res_t res);
    bit   hs;
    bit   done;
    logic prev_clk;
    int   col;
    res.first_rise = 0; res.rises = 0; res.seen = '0; res.lat_start = 0; res.lat_len = 0;
    res.lat_addr = '0; res.oe_start = 0; res.oe_low = 0; res.ready_at = 0;
    row_if.row_in = v.row;
    row_if.row_address_in = v.addr;
    row_if.row_valid_in = 1'b1;
`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
    brightness_in = v.bright;
`endif
    hs = 1'b0;
    for (int w = 0; w < 3000 && !hs; w++) begin
      hs = row_if.row_ready_out;
      @(posedge clk_in); #1;
    end
    if (!hs) begin
      row_if.row_valid_in = 1'b0;
      return;
    end
    if (!v.churn) row_if.row_valid_in = 1'b0;
    prev_clk = panel_clk_out;
    done = 1'b0;
    for (int k = 1; k <= 3000 && !done; k++) begin
      @(posedge clk_in); #1;
      if (v.churn && k < N * DIV) begin
        row_if.row_in = rand_row();
        row_if.row_address_in = 4'($urandom);
      end else begin
        row_if.row_valid_in = 1'b0;
      end
      if (panel_clk_out && !prev_clk) begin
        if (res.rises == 0) res.first_rise = k;
        if (res.rises < N) begin
          col = N - 1 - res.rises;
          res.seen.top.red[col]   = panel_top_rgb_out.r;
          res.seen.top.green[col] = panel_top_rgb_out.g;
          res.seen.top.blue[col]  = panel_top_rgb_out.b;
          res.seen.bot.red[col]   = panel_bot_rgb_out.r;
          res.seen.bot.green[col] = panel_bot_rgb_out.g;
          res.seen.bot.blue[col]  = panel_bot_rgb_out.b;
        end
        res.rises++;
      end
      prev_clk = panel_clk_out;
      if (panel_lat_out) begin
        if (res.lat_len == 0) begin
          res.lat_start = k;
          res.lat_addr  = panel_addr_out;
        end
        res.lat_len++;
      end
      if (!panel_oe_n_out) begin
        if (res.oe_low == 0) res.oe_start = k;
        res.oe_low++;
      end
      if (row_if.row_ready_out) begin
        res.ready_at = k;
        done = 1'b1;
      end
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input res_t r);
    check_int({tag, " first_clk_rise"}, r.first_rise, FIRST_RISE_K);
    check_int({tag, " clk_rises"}, r.rises, N);
    check_row({tag, " shifted_row"}, r.seen, v.row);
    check_int({tag, " lat_start"}, r.lat_start, LAT_K);
    check_int({tag, " lat_len"}, r.lat_len, L);
    check_int({tag, " lat_addr"}, int'(r.lat_addr), int'(v.addr));
    check_int({tag, " oe_low_cycles"}, r.oe_low, v.exp_oe_low);
    if (v.exp_oe_low > 0) check_int({tag, " oe_start"}, r.oe_start, OE_K);
    check_int({tag, " ready_at"}, r.ready_at, READY_K);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_int({tag, " ready"}, int'(row_if.row_ready_out), 0);
    check_int({tag, " oe_n"}, int'(panel_oe_n_out), 1);
    check_int({tag, " panel_clk"}, int'(panel_clk_out), 0);
    check_int({tag, " lat"}, int'(panel_lat_out), 0);
    check_int({tag, " top_rgb"}, int'(panel_top_rgb_out), 0);
    check_int({tag, " bot_rgb"}, int'(panel_bot_rgb_out), 0);
    check_int({tag, " addr"}, int'(panel_addr_out), 0);
  endtask

  vec_t tbl[4];
  vec_t v;
  res_t r;
  int   bad;
  bit   hs;

  initial begin
    tbl[0].row = '0; tbl[0].row.top.red = 32'h8000_0001;
    tbl[0].addr = 4'd5;  tbl[0].bright = 8'd128; tbl[0].churn = 1'b0; tbl[0].exp_oe_low = BR ? 500 : 1000;
    tbl[1].row = '1;
    tbl[1].addr = 4'd10; tbl[1].bright = 8'd0;   tbl[1].churn = 1'b0; tbl[1].exp_oe_low = BR ? 0 : 1000;
    tbl[2].row = '0; tbl[2].row.top.green = 32'hA5A5_5A5A; tbl[2].row.bot.blue = 32'h0F0F_F0F0;
    tbl[2].row.bot.red = 32'h1234_5678; tbl[2].row.top.blue = 32'hDEAD_BEEF;
    tbl[2].addr = 4'd3;  tbl[2].bright = 8'd255; tbl[2].churn = 1'b1; tbl[2].exp_oe_low = BR ? 996 : 1000;
    tbl[3].row = '0; tbl[3].row.bot.green = 32'h0000_8000;
    tbl[3].addr = 4'd15; tbl[3].bright = 8'd64;  tbl[3].churn = 1'b0; tbl[3].exp_oe_low = BR ? 250 : 1000;

    row_if.row_in = '0;
    row_if.row_valid_in = 1'b0;
    row_if.row_address_in = '0;
`ifdef LED_DISPLAY_ROW_DRIVER_BRIGHTNESS_EN
    brightness_in = '0;
`endif
    n_reset_in = 1'b1;
    #1 n_reset_in = 1'b0;
    #1 check_reset_outputs("in_reset");
    @(posedge clk_in); @(posedge clk_in); #1;
    check_int("ready_held_in_reset", int'(row_if.row_ready_out), 0);
    n_reset_in = 1'b1;
    @(posedge clk_in); #1;
    check_int("ready_after_release", int'(row_if.row_ready_out), 1);

    // Idle with no upstream data: panel stays dark and quiet
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_in); #1;
      if (!panel_oe_n_out || panel_clk_out || panel_lat_out || !row_if.row_ready_out) bad++;
    end
    check_int("idle_dark_cycles_bad", bad, 0);

    for (int i = 0; i < 4; i++) begin
      run_row(tbl[i], r);
      check_result($sformatf("vec%0d", i), tbl[i], r);
    end

    // Random rows back-to-back, addresses 0..15 in order
    for (int i = 0; i < 16; i++) begin
      v.row = rand_row();
      v.addr = 4'(i);
      v.bright = 8'($urandom_range(0, 255));
      v.churn = 1'b0;
      v.exp_oe_low = oe_model(int'(v.bright));
      run_row(v, r);
      check_result($sformatf("rand%0d", i), v, r);
    end

    // Asynchronous reset in the middle of SHIFT
    row_if.row_in = rand_row();
    row_if.row_address_in = 4'd9;
    row_if.row_valid_in = 1'b1;
    hs = 1'b0;
    for (int w = 0; w < 3000 && !hs; w++) begin
      hs = row_if.row_ready_out;
      @(posedge clk_in); #1;
    end
    check_int("midshift_handshake", int'(hs), 1);
    row_if.row_valid_in = 1'b0;
    repeat (41) @(posedge clk_in);
    #1 n_reset_in = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(posedge clk_in);
    #1 check_reset_outputs("reset_held");
    n_reset_in = 1'b1;
    @(posedge clk_in); #1;
    check_int("ready_after_midshift_reset", int'(row_if.row_ready_out), 1);
    run_row(tbl[0], r);
    check_result("restart", tbl[0], r);

    check_int("invariant_violations", inv_fail, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
